// File: rtl/ir_byte_tx_pkg.sv
// Shared types and constants for the two-byte instruction transmitter and the IR decoder.
package ir_byte_tx_pkg;

  localparam int INSTR_W = 16;
  localparam int BYTE_W  = 8;
  localparam int OPC_W   = 3;
  localparam int ADDR_W  = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2
  } tx_state_t;

  typedef enum logic [OPC_W-1:0] {
    OPC_NOP = 3'b000,
    OPC_LDA = 3'b001,
    OPC_STA = 3'b010,
    OPC_ADD = 3'b011,
    OPC_SUB = 3'b100,
    OPC_JMP = 3'b101,
    OPC_JZ  = 3'b110,
    OPC_HLT = 3'b111
  } opcode_t;

  function automatic logic [INSTR_W-1:0] pack_instr(input logic [OPC_W-1:0]  opc,
                                                     input logic [ADDR_W-1:0] addr);
    return {opc, addr};
  endfunction

endpackage

// File: rtl/ir_byte_tx_if.sv
// Instruction handshake plus byte-wide memory write bus of the program loader.
interface ir_byte_tx_if;
  import ir_byte_tx_pkg::*;

  logic                instr_valid;
  logic                instr_ready;
  logic [OPC_W-1:0]    opcode;
  logic [ADDR_W-1:0]   addr_in;
  logic                load_base;
  logic [ADDR_W-1:0]   start_addr;
  logic                mem_ack;
  logic [BYTE_W-1:0]   data_bus;
  logic                data_oe;
  logic                wr;
  logic [ADDR_W-1:0]   mem_addr;
  logic                busy;
  logic                wrapped;

  // loader / memory side
  modport master (
    output instr_valid, opcode, addr_in, load_base, start_addr, mem_ack,
    input  instr_ready, data_bus, data_oe, wr, mem_addr, busy, wrapped
  );

  // transmitter side
  modport slave (
    input  instr_valid, opcode, addr_in, load_base, start_addr, mem_ack,
    output instr_ready, data_bus, data_oe, wr, mem_addr, busy, wrapped
  );

endinterface

// File: rtl/ir_wr_ptr.sv
// Loadable incrementing write pointer with a sticky flag that records a wrap to zero.
module ir_wr_ptr #(
  parameter int                ADDR_W    = 13,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk_ctrl,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr,
  output logic              wrapped
);

  always_ff @(posedge clk_ctrl or negedge reset_n) begin
    if (!reset_n) begin
      ptr     <= BASE_ADDR;
      wrapped <= 1'b0;
    end else if (load) begin
      ptr     <= load_val;
      wrapped <= 1'b0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
      if (&ptr) wrapped <= 1'b1;
    end
  end

endmodule

// File: rtl/ir_byte_tx.sv
// Sends one {opcode, addr} word as two byte writes, high byte first, at consecutive pointer addresses.
//
// state   | meaning
// IDLE    | ready for a word; bus released
// HI      | high byte {opcode, addr[12:8]} on the bus, waiting for mem_ack
// LO      | low byte addr[7:0] on the bus, waiting for mem_ack
module ir_byte_tx #(
  parameter int                ADDR_W    = 13,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic          clk_ctrl,
  input  logic          reset_n,
  ir_byte_tx_if.slave   bus
);
  import ir_byte_tx_pkg::*;

  tx_state_t           state;
  logic [BYTE_W-1:0]   data_q;
  logic [BYTE_W-1:0]   lo_byte_q;
  logic                oe_q;
  logic                wr_q;
  logic [INSTR_W-1:0]  next_word;
  logic                ptr_load;
  logic                ptr_inc;
  logic [ADDR_W-1:0]   ptr;
  logic                wrapped;

  assign next_word = pack_instr(bus.opcode, bus.addr_in);

  // the pointer only moves on a load in IDLE or on each acknowledged byte
  assign ptr_load = bus.load_base && (state == ST_IDLE);
  assign ptr_inc  = bus.mem_ack && (state != ST_IDLE);

  ir_wr_ptr #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_wr_ptr (
    .clk_ctrl (clk_ctrl),
    .reset_n  (reset_n),
    .load     (ptr_load),
    .load_val (bus.start_addr),
    .inc      (ptr_inc),
    .ptr      (ptr),
    .wrapped  (wrapped)
  );

  always_ff @(posedge clk_ctrl or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      data_q    <= '0;
      lo_byte_q <= '0;
      oe_q      <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.instr_valid) begin
            data_q    <= next_word[INSTR_W-1:BYTE_W];
            lo_byte_q <= next_word[BYTE_W-1:0];
            oe_q      <= 1'b1;
            wr_q      <= 1'b1;
            state     <= ST_HI;
          end
        end
        ST_HI: begin
          if (bus.mem_ack) begin
            data_q <= lo_byte_q;
            state  <= ST_LO;
          end
        end
        ST_LO: begin
          if (bus.mem_ack) begin
            data_q    <= '0;
            lo_byte_q <= '0;
            oe_q      <= 1'b0;
            wr_q      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          data_q    <= '0;
          lo_byte_q <= '0;
          oe_q      <= 1'b0;
          wr_q      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.instr_ready = (state == ST_IDLE);
  assign bus.busy        = (state != ST_IDLE);
  assign bus.data_bus    = data_q;
  assign bus.data_oe     = oe_q;
  assign bus.wr          = wr_q;
  assign bus.mem_addr    = ptr;
  assign bus.wrapped     = wrapped;

endmodule
